ascon_sub_layer_ti_serial: RTL and testbench
============================================

Name: ascon_sub_layer_ti_serial

Overview:
- Iterative, parametrised successor to the single-slice 3-share threshold-implementation (TI) Ascon S-box.
- Accepts a full 3-share masked Ascon state (5 lanes x LANE_W bits per share) and applies the Ascon substitution layer to every bit-slice.
- Processes SLICES bit-slices per clock, with a register barrier between the non-linear share functions and the state.
- Sits between the masked constant-addition and linear-diffusion stages of the masked Ascon permutation core.

Parameters:
- LANE_W, 64, bits per lane; total state per share is 5*LANE_W.
- SLICES, 8, S-box instances (bit-slices) processed per cycle; LANE_W % SLICES must be 0, checked at elaboration.
- N (derived), LANE_W/SLICES, number of compute cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input shared state valid.
- in_ready  out  1  block can accept a state.
- in_s0, in_s1, in_s2  in  5*LANE_W  input shares; lane k at bits [k*LANE_W +: LANE_W]; lane 0 = x0.
- out_valid  out  1  result shares valid.
- out_ready  in  1  consumer accepts result.
- out_s0, out_s1, out_s2  out  5*LANE_W  output shares, same packing as the inputs.
- busy  out  1  high in RUN or DONE.

Behaviour:
Slice b
- Slice b is bit b of each of lanes x0..x4.

Unshared S-box (y = S(x)), applied in order:
- x0^=x4; x4^=x3; x2^=x1.
- t_i = ~x_i & x_(i+1 mod 5), computed for all i.
- x_i ^= t_(i+1 mod 5).
- x1^=x0; x0^=x4; x3^=x2; x2=~x2.

Share functions (per slice):
- Correctness: XOR of the three output shares = S(XOR of the three input shares).
- Non-completeness: each output share of every coordinate depends on at most two input shares.
- The constant 1 for x2 is added in exactly one share.
- Share functions are purely combinational; all outputs of the share functions are registered before reuse.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_s0..in_s2 into three share registers, clear slice counter, go to RUN.
- RUN (N cycles):
  - Each cycle, process slices [cnt*SLICES +: SLICES] of every lane through SLICES TI S-box instances.
  - Write the results back to the same bit positions; cnt increments.
  - Chunks are processed in ascending slice order.
  - When cnt == N-1, go to DONE on that edge.
- DONE:
  - out_valid=1; out_s* drive the share registers.
  - Outputs are held stable while out_ready=0.
  - On out_ready, return to IDLE.

Timing and handshake:
- Latency: the acceptance edge T is followed by compute edges T+1..T+N; out_valid is high after edge T+N.
- Throughput: one state per N+2 cycles.
- in_ready=0 in RUN and DONE; in_valid is ignored there.
- A DONE->IDLE transition and a new acceptance cannot occur in the same cycle. in_ready is a function of the registered state only.
- out_valid and in_ready are registered-state decodes (no combinational path from in_valid or out_ready).

Reset (asserted at any time, including mid-RUN or during DONE):
- State=IDLE, cnt=0, all share registers=0.
- out_valid=0, busy=0, in_ready=1 after reset.
- out_s* = 0 while in reset.
- No partial result is ever presented.

Degenerate configuration:
- SLICES == LANE_W gives N=1, i.e. a single compute cycle.

Test Plan:
1. Zero state: LANE_W=64, SLICES=8, all input shares 0.
   - out_valid rises 8 cycles after the acceptance edge.
   - XOR of outputs: lanes 0,1,3,4 = 0; lane 2 = all ones (S(0)=0x04).
2. Masked ones: unmasked state all ones, with s1 and s2 random and s0 = ones^s1^s2.
   - XOR of outputs: lanes 0,2,3,4 all ones; lane 1 = 0 (S(0x1F)=0x17).
3. Exhaustive table: drive slice b with unmasked value b mod 32 under fresh random masks.
   - Every slice's XOR matches the Ascon table 04,0b,1f,14,1a,15,09,02,1b,05,08,12,1d,03,06,1c,1e,13,07,0e,00,0d,11,18,10,0c,01,19,16,0a,0f,17 (x0 = MSB).
   - Repeat with SLICES=1, 16 and 64.
4. Backpressure: hold out_ready=0 for 20 cycles after DONE.
   - out_s* stay constant; in_ready stays 0; a pulse on in_valid is ignored.
   - Raising out_ready gives in_ready=1 on the next cycle.
5. Reset mid-run: assert rst at cnt=3.
   - Immediately: out_valid=0 and all out_s*=0.
   - After release: a new state is accepted and its result is correct and unaffected by the aborted run.
6. Mask independence: same unmasked state processed 1000 times with random masks.
   - Unmasked result is constant each time; each individual output share varies.

Source files
------------

// File: rtl/ascon_sub_layer_ti_serial.sv
// ascon_sub_layer_ti_serial: iterative 3-share TI Ascon substitution layer, SLICES bit-slices per cycle.
module ascon_sub_layer_ti_serial #(
    parameter int LANE_W = 64,
    parameter int SLICES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5*LANE_W-1:0] in_s0,
    input  logic [5*LANE_W-1:0] in_s1,
    input  logic [5*LANE_W-1:0] in_s2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5*LANE_W-1:0] out_s0,
    output logic [5*LANE_W-1:0] out_s1,
    output logic [5*LANE_W-1:0] out_s2,
    output logic                busy
);
    localparam int W  = 5 * LANE_W;
    localparam int N  = LANE_W / SLICES;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    generate
        if (LANE_W % SLICES != 0) begin : g_bad_cfg
            $error("LANE_W must be a multiple of SLICES");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    s0_q, s1_q, s2_q;
    logic [W-1:0]    s0_d, s1_d, s2_d;

    function automatic logic [4:0] lin_pre(input logic [4:0] x);
        logic [4:0] y;
        y = x;
        y[0] = y[0] ^ y[4];
        y[4] = y[4] ^ y[3];
        y[2] = y[2] ^ y[1];
        return y;
    endfunction

    function automatic logic [4:0] lin_post(input logic [4:0] x);
        logic [4:0] y;
        y = x;
        y[1] = y[1] ^ y[0];
        y[0] = y[0] ^ y[4];
        y[3] = y[3] ^ y[2];
        return y;
    endfunction

    // Output share 0 uses input shares 1,2; share 1 uses 2,0; share 2 uses 0,1.
    // The negation of the chi operand lives only in input share 0 (n0).
    function automatic logic [14:0] ti_sbox(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        logic [4:0] p0, p1, p2, n0, q0, q1, q2;
        int j, k;
        p0 = lin_pre(a0);
        p1 = lin_pre(a1);
        p2 = lin_pre(a2);
        n0 = ~p0;
        q0 = '0;
        q1 = '0;
        q2 = '0;
        for (int i = 0; i < 5; i++) begin
            j = (i + 1) % 5;
            k = (i + 2) % 5;
            q0[i] = p1[i] ^ (p1[j] & p1[k]) ^ (p1[j] & p2[k]) ^ (p2[j] & p1[k]);
            q1[i] = p2[i] ^ (p2[j] & p2[k]) ^ (p2[j] & p0[k]) ^ (n0[j] & p2[k]);
            q2[i] = p0[i] ^ (n0[j] & p0[k]) ^ (n0[j] & p1[k]) ^ (p1[j] & p0[k]);
        end
        q0 = lin_post(q0);
        q0[2] = ~q0[2];
        q1 = lin_post(q1);
        q2 = lin_post(q2);
        return {q2, q1, q0};
    endfunction

    always_comb begin
        logic [4:0]  a0, a1, a2;
        logic [14:0] r;
        int          idx;
        s0_d = s0_q;
        s1_d = s1_q;
        s2_d = s2_q;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        r = '0;
        idx = 0;
        for (int j = 0; j < SLICES; j++) begin
            idx = int'(cnt_q) * SLICES + j;
            for (int k = 0; k < 5; k++) begin
                a0[k] = s0_q[k*LANE_W+idx];
                a1[k] = s1_q[k*LANE_W+idx];
                a2[k] = s2_q[k*LANE_W+idx];
            end
            r = ti_sbox(a0, a1, a2);
            for (int k = 0; k < 5; k++) begin
                s0_d[k*LANE_W+idx] = r[k];
                s1_d[k*LANE_W+idx] = r[5+k];
                s2_d[k*LANE_W+idx] = r[10+k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    s0_q    <= in_s0;
                    s1_q    <= in_s1;
                    s2_q    <= in_s2;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    s0_q  <= s0_d;
                    s1_q  <= s1_d;
                    s2_q  <= s2_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N - 1)) state_q <= DONE;
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    // Shares are only exposed once complete, so no partially substituted state leaks out.
    assign out_s0    = out_valid ? s0_q : '0;
    assign out_s1    = out_valid ? s1_q : '0;
    assign out_s2    = out_valid ? s2_q : '0;
endmodule

// File: tb/tb_ascon_sub_layer_ti_serial.sv
// tb_ascon_sub_layer_ti_serial: randomized checks of the TI substitution layer against an unshared S-box model.
module tb_ascon_sub_layer_ti_serial;
    localparam int LW = 64;
    localparam int W  = 5 * LW;
    localparam int SL [4] = '{8, 1, 16, 64};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_s0 = '0, in_s1 = '0, in_s2 = '0;
    logic         in_ready [4];
    logic         out_valid [4];
    logic         busy [4];
    logic [W-1:0] o0 [4], o1 [4], o2 [4];
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    generate
        for (genvar d = 0; d < 4; d++) begin : g_dut
            ascon_sub_layer_ti_serial #(.LANE_W(LW), .SLICES(SL[d])) dut (
                .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[d]),
                .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
                .out_valid(out_valid[d]), .out_ready(out_ready),
                .out_s0(o0[d]), .out_s1(o1[d]), .out_s2(o2[d]), .busy(busy[d])
            );
        end
    endgenerate

    // Unshared Ascon S-box straight from the algorithm; x0 is the MSB of v.
    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [4:0] x, t;
        for (int i = 0; i < 5; i++) x[i] = v[4-i];
        x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
        for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1)%5];
        for (int i = 0; i < 5; i++) x[i] ^= t[(i+1)%5];
        x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [W-1:0] model(input logic [W-1:0] x);
        logic [W-1:0] y;
        logic [4:0] v, s;
        y = '0;
        for (int b = 0; b < LW; b++) begin
            for (int k = 0; k < 5; k++) v[4-k] = x[k*LW+b];
            s = sbox(v);
            for (int k = 0; k < 5; k++) y[k*LW+b] = s[4-k];
        end
        return y;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        int n = 0;
        while (!in_ready[0] && n < 200) begin @(posedge clk); #1; n++; end
        if (!in_ready[0]) begin total++; bad++; $display("FAIL start_timeout in_ready=%0b want=1", in_ready[0]); end
        @(negedge clk);
        in_s0 = a; in_s1 = b; in_s2 = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid[0] && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!out_valid[0]) begin total++; bad++; $display("FAIL done_timeout out_valid=%0b want=1", out_valid[0]); end
    endtask

    task automatic release_out();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic xfer(input logic [W-1:0] x, output logic [W-1:0] y, output logic [W-1:0] r0);
        logic [W-1:0] m1, m2;
        int lat;
        m1 = rnd(); m2 = rnd();
        start(x ^ m1 ^ m2, m1, m2);
        wait_done(lat);
        y = o0[0] ^ o1[0] ^ o2[0];
        r0 = o0[0];
        release_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", out_valid[0]); end
        total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", in_ready[0]); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy[0]); end
        total++; if ((o0[0] | o1[0] | o2[0]) !== '0) begin bad++; $display("FAIL rst_out_s got=%h want=0", o0[0] | o1[0] | o2[0]); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_zero();
        logic [W-1:0] exp;
        int lat;
        exp = '0; exp[2*LW +: LW] = '1;
        start('0, '0, '0);
        wait_done(lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL zero_latency got=%0d want=8", lat); end
        total++; if ((o0[0] ^ o1[0] ^ o2[0]) !== exp) begin bad++; $display("FAIL zero_result got=%h want=%h", o0[0] ^ o1[0] ^ o2[0], exp); end
        release_out();
        total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL zero_back_idle got=%0b want=1", in_ready[0]); end
    endtask

    task automatic test_ones();
        logic [W-1:0] exp, y, r0;
        exp = '1; exp[LW +: LW] = '0;
        xfer('1, y, r0);
        total++; if (y !== exp) begin bad++; $display("FAIL ones_result got=%h want=%h", y, exp); end
    endtask

    task automatic test_table();
        logic [4:0] tbl [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
        logic [W-1:0] x, exp, m1, m2;
        logic [W-1:0] y [4];
        logic [4:0] v, s;
        int lat [4];
        x = '0; exp = '0;
        for (int b = 0; b < LW; b++) begin
            v = 5'(b % 32);
            s = tbl[b % 32];
            for (int k = 0; k < 5; k++) begin x[k*LW+b] = v[4-k]; exp[k*LW+b] = s[4-k]; end
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m1 = rnd(); m2 = rnd();
        start(x ^ m1 ^ m2, m1, m2);
        for (int d = 0; d < 4; d++) begin lat[d] = -1; y[d] = '0; end
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++)
                if (out_valid[d] && lat[d] < 0) begin lat[d] = c; y[d] = o0[d] ^ o1[d] ^ o2[d]; end
            if (lat[0] > 0 && lat[1] > 0 && lat[2] > 0 && lat[3] > 0) break;
        end
        for (int d = 0; d < 4; d++) begin
            total++; if (lat[d] !== LW / SL[d]) begin bad++; $display("FAIL table_latency slices=%0d got=%0d want=%0d", SL[d], lat[d], LW / SL[d]); end
            total++; if (y[d] !== exp) begin bad++; $display("FAIL table_result slices=%0d got=%h want=%h", SL[d], y[d], exp); end
        end
        release_out();
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, r0;
        for (int i = 0; i < 8; i++) begin
            x = rnd();
            xfer(x, y, r0);
            total++; if (y !== model(x)) begin bad++; $display("FAIL random_%0d got=%h want=%h", i, y, model(x)); end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] x, m1, m2, r0, r1, r2;
        logic held;
        int lat;
        x = rnd(); m1 = rnd(); m2 = rnd();
        start(x ^ m1 ^ m2, m1, m2);
        wait_done(lat);
        r0 = o0[0]; r1 = o1[0]; r2 = o2[0];
        total++; if ((r0 ^ r1 ^ r2) !== model(x)) begin bad++; $display("FAIL bp_result got=%h want=%h", r0 ^ r1 ^ r2, model(x)); end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = (i == 5);
            in_s0 = rnd();
            @(posedge clk); #1;
            if (o0[0] !== r0 || o1[0] !== r1 || o2[0] !== r2 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) held = 1'b0;
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL bp_hold got=%0b want=1", held); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%0b want=1", in_ready[0]); end
        total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL bp_out_valid got=%0b want=0", out_valid[0]); end
        @(negedge clk); out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL bp_pulse_ignored busy=%0b want=0", busy[0]); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, m1, m2, y, r0;
        x = rnd(); m1 = rnd(); m2 = rnd();
        start(x ^ m1 ^ m2, m1, m2);
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin bad++; $display("FAIL mid_running busy=%0b out_valid=%0b want=1/0", busy[0], out_valid[0]); end
        total++; if ((o0[0] | o1[0] | o2[0]) !== '0) begin bad++; $display("FAIL mid_no_partial got=%h want=0", o0[0] | o1[0] | o2[0]); end
        rst = 1'b1;
        #1;
        total++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl out_valid=%0b in_ready=%0b busy=%0b want=0/1/0", out_valid[0], in_ready[0], busy[0]); end
        total++; if ((o0[0] | o1[0] | o2[0]) !== '0) begin bad++; $display("FAIL mid_rst_out_s got=%h want=0", o0[0] | o1[0] | o2[0]); end
        @(negedge clk); rst = 1'b0;
        x = rnd();
        xfer(x, y, r0);
        total++; if (y !== model(x)) begin bad++; $display("FAIL mid_after got=%h want=%h", y, model(x)); end
    endtask

    task automatic test_mask();
        logic [W-1:0] x, exp, y, r0, first;
        logic varied;
        int errs = 0;
        x = rnd();
        exp = model(x);
        varied = 1'b0;
        first = '0;
        for (int i = 0; i < 1000; i++) begin
            xfer(x, y, r0);
            if (i == 0) first = r0;
            else if (r0 !== first) varied = 1'b1;
            total++;
            if (y !== exp) begin
                bad++; errs++;
                if (errs <= 3) $display("FAIL mask_%0d got=%h want=%h", i, y, exp);
            end
        end
        total++; if (varied !== 1'b1) begin bad++; $display("FAIL mask_share_varies got=%0b want=1", varied); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_table();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_mask();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
